// File: rtl/io_input_conditioner_pkg.sv
// Shared widths, bit positions and default timing for the IO input conditioner.
package io_defs;

  localparam int IO_SW_W    = 10;
  localparam int IO_KEY_W   = 4;
  localparam int IO_IN_W    = 14;
  localparam int IO_SW_LSB  = 0;
  localparam int IO_KEY_LSB = 10;

  localparam int IO_TICK_DIV_DEF       = 1000;
  localparam int IO_DEBOUNCE_TICKS_DEF = 16;

  // Counter only has to reach DEBOUNCE_TICKS-1; keep at least one bit.
  function automatic int cnt_width(input int ticks);
    return (ticks <= 2) ? 1 : $clog2(ticks);
  endfunction

endpackage

// File: rtl/io_input_conditioner_debounce_bit.sv
// One input bit: 2-flop synchronizer followed by a tick-qualified debounce counter.
module debounce_bit
  import io_defs::*;
#(
  parameter logic RESET_VAL      = 1'b0,
  parameter int   DEBOUNCE_TICKS = IO_DEBOUNCE_TICKS_DEF,
  parameter int   CNT_W          = cnt_width(IO_DEBOUNCE_TICKS_DEF)
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic pin,
  output logic stable
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1  <= RESET_VAL;
      sync2  <= RESET_VAL;
      stable <= RESET_VAL;
      cnt    <= '0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      // Any return to the stable level restarts qualification.
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CNT_LAST) begin
          stable <= sync2;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/io_input_conditioner.sv
// Debounces slide switches and push keys for the memory-mapped IO read path.
// Optional IO_KEY_TOGGLE_EN: key bits of io_input_bus become per-key toggle registers.
module io_input_conditioner
  import io_defs::*;
#(
  parameter int TICK_DIV       = IO_TICK_DIV_DEF,
  parameter int DEBOUNCE_TICKS = IO_DEBOUNCE_TICKS_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [IO_SW_W-1:0]  sw_in,
  input  logic [IO_KEY_W-1:0] key_n_in,
  output logic [IO_IN_W-1:0]  io_input_bus,
  output logic [IO_KEY_W-1:0] key_event
);

  localparam int CNT_W = cnt_width(DEBOUNCE_TICKS);

  logic [15:0]         presc;
  logic                tick;
  logic [IO_SW_W-1:0]  sw_lvl;
  logic [IO_KEY_W-1:0] key_raw;
  logic [IO_KEY_W-1:0] key_lvl;
  logic [IO_KEY_W-1:0] key_prev;
  logic [IO_KEY_W-1:0] key_field;

  assign tick = (presc == 16'(TICK_DIV - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 16'd1;
    end
  end

  for (genvar i = 0; i < IO_SW_W; i++) begin : g_sw
    debounce_bit #(
      .RESET_VAL      (1'b0),
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .CNT_W          (CNT_W)
    ) u_db (
      .clock  (clock),
      .reset  (reset),
      .tick   (tick),
      .pin    (sw_in[i]),
      .stable (sw_lvl[i])
    );
  end

  // Keys are debounced in raw polarity (reset = released = 1) and inverted afterwards.
  for (genvar i = 0; i < IO_KEY_W; i++) begin : g_key
    debounce_bit #(
      .RESET_VAL      (1'b1),
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .CNT_W          (CNT_W)
    ) u_db (
      .clock  (clock),
      .reset  (reset),
      .tick   (tick),
      .pin    (key_n_in[i]),
      .stable (key_raw[i])
    );
  end

  assign key_lvl = ~key_raw;

  always_ff @(posedge clock) begin
    if (reset) begin
      key_prev <= '0;
    end else begin
      key_prev <= key_lvl;
    end
  end

  assign key_event = key_lvl & ~key_prev;

`ifdef IO_KEY_TOGGLE_EN
  logic [IO_KEY_W-1:0] key_tog;

  always_ff @(posedge clock) begin
    if (reset) begin
      key_tog <= '0;
    end else begin
      key_tog <= key_tog ^ key_event;
    end
  end

  assign key_field = key_tog;
`else
  assign key_field = key_lvl;
`endif

  assign io_input_bus[IO_SW_LSB +: IO_SW_W]   = sw_lvl;
  assign io_input_bus[IO_KEY_LSB +: IO_KEY_W] = key_field;

endmodule

// File: tb/tb_io_input_conditioner.sv
// Self-checking bench for io_input_conditioner: vector table plus multi-cycle corner sequences.
module tb_io_input_conditioner;

`ifdef IO_KEY_TOGGLE_EN
  localparam bit TOG = 1'b1;
`else
  localparam bit TOG = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        rst_a, rst_b;
  logic [9:0]  sw_a, sw_b;
  logic [3:0]  kn_a, kn_b;
  logic [13:0] bus_a, bus_b;
  logic [3:0]  ev_a, ev_b;

  always #5 clock = ~clock;

  io_input_conditioner #(.TICK_DIV(1), .DEBOUNCE_TICKS(4)) dut_a (
    .clock        (clock),
    .reset        (rst_a),
    .sw_in        (sw_a),
    .key_n_in     (kn_a),
    .io_input_bus (bus_a),
    .key_event    (ev_a)
  );

  io_input_conditioner #(.TICK_DIV(5), .DEBOUNCE_TICKS(2)) dut_b (
    .clock        (clock),
    .reset        (rst_b),
    .sw_in        (sw_b),
    .key_n_in     (kn_b),
    .io_input_bus (bus_b),
    .key_event    (ev_b)
  );

  typedef struct {
    logic [9:0]  sw;
    logic [3:0]  kn;
    int          cyc;
    logic [13:0] bus;
    logic [3:0]  ev;
  } vec_t;

  typedef struct {
    logic [13:0] bus;
    logic [3:0]  ev;
  } exp_t;

  vec_t vecs[9];
  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic measure_b(input string nm, output int n);
    n = 0;
    while (bus_b[9] !== 1'b1 && n < 40) begin
      step(1);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   evs;
    exp_t e;

    vecs[0] = '{10'h000, 4'hF, 5, 14'h03FF, 4'h0};
    vecs[1] = '{10'h000, 4'hF, 1, 14'h0000, 4'h0};
    vecs[2] = '{10'h008, 4'hF, 5, 14'h0000, 4'h0};
    vecs[3] = '{10'h008, 4'hF, 1, 14'h0008, 4'h0};
    vecs[4] = '{10'h0A9, 4'hF, 6, 14'h00A9, 4'h0};
    vecs[5] = '{10'h0A9, 4'h5, 5, 14'h00A9, 4'h0};
    vecs[6] = '{10'h0A9, 4'h5, 1, TOG ? 14'h00A9 : 14'h28A9, 4'hA};
    vecs[7] = '{10'h0A9, 4'h5, 1, 14'h28A9, 4'h0};
    vecs[8] = '{10'h0A9, 4'hF, 6, TOG ? 14'h28A9 : 14'h00A9, 4'h0};

    rst_a = 1'b1; rst_b = 1'b1;
    sw_a = 10'h3FF; kn_a = 4'hF;
    sw_b = 10'h000; kn_b = 4'hF;
    step(3);
    check("rst_bus_a", 16'(bus_a), 16'h0000);
    check("rst_ev_a", 16'(ev_a), 16'h0000);
    check("rst_bus_b", 16'(bus_b), 16'h0000);

    rst_a = 1'b0;
    step(5);
    check("post_rst_e5", 16'(bus_a), 16'h0000);
    step(1);
    check("post_rst_e6", 16'(bus_a), 16'h03FF);
    check("post_rst_ev", 16'(ev_a), 16'h0000);

    for (int i = 0; i < 9; i++) begin
      sw_a = vecs[i].sw;
      kn_a = vecs[i].kn;
      exp_q.push_back('{vecs[i].bus, vecs[i].ev});
      step(vecs[i].cyc);
      e = exp_q.pop_front();
      check($sformatf("vec%0d_bus", i), 16'(bus_a), 16'(e.bus));
      check($sformatf("vec%0d_ev", i), 16'(ev_a), 16'(e.ev));
    end

    // Glitch of three cycles is one short of qualifying.
    sw_a = 10'h000;
    step(6);
    check("glitch_base", 16'(bus_a[9:0]), 16'h0000);
    sw_a[0] = 1'b1;
    step(3);
    sw_a[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check($sformatf("glitch3_c%0d", i), 16'(bus_a[0]), 16'h0000);
    end

    // Four-cycle pulse just qualifies, then qualifies back to 0.
    sw_a[0] = 1'b1;
    step(4);
    sw_a[0] = 1'b0;
    step(1);
    check("pulse4_e5", 16'(bus_a[0]), 16'h0000);
    step(1);
    check("pulse4_e6", 16'(bus_a[0]), 16'h0001);
    step(3);
    check("pulse4_e9", 16'(bus_a[0]), 16'h0001);
    step(1);
    check("pulse4_e10", 16'(bus_a[0]), 16'h0000);

    // Key 2 with bounce 0,1,0 then held.
    kn_a[2] = 1'b0;
    step(1);
    kn_a[2] = 1'b1;
    step(1);
    kn_a[2] = 1'b0;
    step(5);
    check("bounce_e7_bus", 16'(bus_a), 16'h0000);
    check("bounce_e7_ev", 16'(ev_a), 16'h0000);
    step(1);
    check("bounce_e8_bus", 16'(bus_a), TOG ? 16'h0000 : 16'h1000);
    check("bounce_e8_ev", 16'(ev_a), 16'h0004);
    step(1);
    check("bounce_e9_bus", 16'(bus_a), 16'h1000);
    check("bounce_e9_ev", 16'(ev_a), 16'h0000);
    kn_a = 4'hF;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check($sformatf("release_ev_c%0d", i), 16'(ev_a), 16'h0000);
    end
    check("release_bus", 16'(bus_a), TOG ? 16'h1000 : 16'h0000);

    // Prescaled instance: TICK_DIV=5, DEBOUNCE_TICKS=2.
    rst_b = 1'b0;
    sw_b = 10'h200;
    measure_b("b_lat1", n);
    check("b_lat1", 16'(n), 16'd10);
    check("b_window", 16'((n >= 8) && (n <= 16)), 16'd1);
    check("b_other_bits", 16'(bus_b[8:0]), 16'h0000);
    rst_b = 1'b1;
    step(1);
    check("b_rst_clear", 16'(bus_b), 16'h0000);
    rst_b = 1'b0;
    step(7);
    check("b_midcount", 16'(bus_b[9]), 16'h0000);
    rst_b = 1'b1;
    step(1);
    check("b_midrst_bus", 16'(bus_b), 16'h0000);
    rst_b = 1'b0;
    measure_b("b_lat2", n);
    check("b_lat2", 16'(n), 16'd10);

    // Key 0 held pressed through reset deassertion.
    rst_a = 1'b1;
    sw_a = 10'h000;
    kn_a = 4'b1110;
    step(2);
    check("held_rst_bus", 16'(bus_a), 16'h0000);
    check("held_rst_ev", 16'(ev_a), 16'h0000);
    rst_a = 1'b0;
    step(5);
    check("held_e5", 16'(bus_a), 16'h0000);
    step(1);
    check("held_e6_bus", 16'(bus_a), TOG ? 16'h0000 : 16'h0400);
    check("held_e6_ev", 16'(ev_a), 16'h0001);
    step(1);
    check("held_e7_bus", 16'(bus_a), 16'h0400);
    check("held_e7_ev", 16'(ev_a), 16'h0000);

`ifdef IO_KEY_TOGGLE_EN
    begin
      logic exp_tog[3];
      exp_tog = '{1'b1, 1'b0, 1'b1};
      kn_a = 4'hF;
      rst_a = 1'b1;
      step(1);
      rst_a = 1'b0;
      evs = 0;
      for (int k = 0; k < 3; k++) begin
        kn_a[0] = 1'b0;
        for (int c = 0; c < 10; c++) begin
          step(1);
          if (ev_a[0]) evs++;
        end
        check($sformatf("toggle_press%0d", k), 16'(bus_a[10]), 16'(exp_tog[k]));
        kn_a[0] = 1'b1;
        for (int c = 0; c < 8; c++) begin
          step(1);
          if (ev_a[0]) evs++;
        end
        check($sformatf("toggle_hold%0d", k), 16'(bus_a[10]), 16'(exp_tog[k]));
      end
      check("toggle_events", 16'(evs), 16'd3);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
